// File: rtl/alu_seq_if.sv
// Handshake bundle between the execute-unit decoder side and the ALU.
// master drives operands and out_ready; slave is the ALU itself.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [7:0]       flags;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle Z80-style ALU: single-cycle logic/arithmetic, one-bit-per-cycle
// shifts and rotates, Z80 flag layout S Z 0 H 0 PV N C.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [CNTW-1:0]  W_CNT = CNTW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [7:0]       flags_q, flags_d;

    // Immediate-path operand decode
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] mask;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [4:0]       nib_sum, nib_diff;
    logic             in_is_shift;
    logic [CNTW-1:0]  n_in;
    logic [WIDTH-1:0] imm_res;
    logic [7:0]       imm_flags;
    logic             imm_keep_flags;

    // Iterative-path step
    logic [WIDTH-1:0] step_data;
    logic             step_out;
    logic             step_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        idx         = bus.b[IDXW-1:0];
        mask        = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
        sum_ext     = {1'b0, bus.a} + {1'b0, bus.b};
        diff_ext    = {1'b0, bus.a} - {1'b0, bus.b};
        nib_sum     = {1'b0, bus.a[3:0]} + {1'b0, bus.b[3:0]};
        nib_diff    = {1'b0, bus.a[3:0]} - {1'b0, bus.b[3:0]};
        in_is_shift = (bus.opcode inside {4'd6, 4'd7, 4'd8, 4'd9, 4'd10});
        // Rotates wrap the amount; linear shifts saturate at WIDTH
        if (bus.opcode == 4'd10)
            n_in = {{(CNTW-IDXW){1'b0}}, idx};
        else if (bus.b >= W_VAL)
            n_in = W_CNT;
        else
            n_in = bus.b[CNTW-1:0];

        imm_keep_flags = 1'b0;
        imm_res        = '0;
        imm_flags      = '0;
        case (bus.opcode)
            4'd0: begin
                imm_res   = sum_ext[WIDTH-1:0];
                imm_flags = {imm_res[WIDTH-1], imm_res == '0, 1'b0, nib_sum[4], 1'b0,
                             (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (imm_res[WIDTH-1] != bus.a[WIDTH-1]),
                             1'b0, sum_ext[WIDTH]};
            end
            4'd1: begin
                imm_res   = diff_ext[WIDTH-1:0];
                imm_flags = {imm_res[WIDTH-1], imm_res == '0, 1'b0, nib_diff[4], 1'b0,
                             (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (imm_res[WIDTH-1] != bus.a[WIDTH-1]),
                             1'b1, diff_ext[WIDTH]};
            end
            4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
                if (bus.opcode == 4'd2)      imm_res = bus.a & bus.b;
                else if (bus.opcode == 4'd3) imm_res = bus.a | bus.b;
                else if (bus.opcode == 4'd4) imm_res = bus.a ^ bus.b;
                else                         imm_res = bus.a;
                imm_flags = {imm_res[WIDTH-1], imm_res == '0, 1'b0, bus.opcode == 4'd2, 1'b0,
                             ~^imm_res, 1'b0, 1'b0};
            end
            4'd13: begin
                imm_res        = bus.a | mask;
                imm_keep_flags = 1'b1;
            end
            4'd14: begin
                imm_res        = bus.a & ~mask;
                imm_keep_flags = 1'b1;
            end
            4'd15: begin
                imm_res   = bus.a;
                imm_flags = {1'b0, ~bus.a[idx], 1'b0, 1'b1, 4'b0000};
            end
            default: begin
                imm_res   = '0;
                imm_flags = '0;
            end
        endcase
    end

    always_comb begin
        step_data = data_q;
        step_out  = 1'b0;
        case (op_q)
            4'd7:    begin step_data = {1'b0, data_q[WIDTH-1:1]};         step_out = data_q[0];       end
            4'd9:    begin step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]}; step_out = data_q[0];   end
            4'd10:   begin step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]}; step_out = data_q[WIDTH-1]; end
            default: begin step_data = {data_q[WIDTH-2:0], 1'b0};         step_out = data_q[WIDTH-1]; end
        endcase
        step_c = (op_q == 4'd10) ? step_data[0] : step_out;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = (in_is_shift && n_in != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt_q == CNTW'(1)) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath register updates
    always_comb begin
        op_d     = op_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d   = bus.opcode;
                    data_d = bus.a;
                    cnt_d  = n_in;
                    if (!(in_is_shift && n_in != '0)) begin
                        result_d = imm_res;
                        if (!imm_keep_flags) flags_d = imm_flags;
                    end
                end
            end
            SHIFT: begin
                data_d = step_data;
                cnt_d  = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    result_d = step_data;
                    flags_d  = {step_data[WIDTH-1], step_data == '0, 1'b0, 1'b0, 1'b0,
                                ~^step_data, 1'b0, step_c};
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.flags     = flags_q;
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: flag vectors, shift latencies, backpressure,
// mid-operation reset, and a 16-bit wraparound add.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   lat;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  if8 ();
    alu_seq_if #(.WIDTH(16)) if16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 8-bit DUT and wait (bounded) for out_valid.
    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int cycles);
        @(negedge clk);
        check("in_ready_idle", {31'd0, if8.in_ready}, 32'd1);
        if8.opcode   = op;
        if8.a        = a;
        if8.b        = b;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        if8.a        = ~a;
        if8.b        = 8'h01;
        if8.opcode   = 4'd5;
        cycles = 1;
        while (!if8.out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic pop8;
        @(negedge clk);
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b0;
    endtask

    task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic [7:0] exp_flags, input int exp_lat);
        int cyc;
        issue8(op, a, b, cyc);
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_res"}, {24'd0, if8.result}, {24'd0, exp_res});
        check({tag, "_flags"}, {24'd0, if8.flags}, {24'd0, exp_flags});
        $display("[TB] %s op=%0d a=%h b=%h -> result=%h flags=%h lat=%0d", tag, op, a, b, if8.result, if8.flags, cyc);
        pop8();
    endtask

    initial begin
        bit saw_valid;
        int cyc16;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.opcode = '0; if8.out_ready = 1'b0;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.opcode = '0; if16.out_ready = 1'b0;

        #12;
        check("rst_in_ready", {31'd0, if8.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, if8.out_valid}, 32'd0);
        check("rst_result", {24'd0, if8.result}, 32'd0);
        check("rst_flags", {24'd0, if8.flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8("add_07_07", 4'd0,  8'h07, 8'h07, 8'h0E, 8'h00, 1);
        run8("sub_07_07", 4'd1,  8'h07, 8'h07, 8'h00, 8'h42, 1);
        run8("add_7F_01", 4'd0,  8'h7F, 8'h01, 8'h80, 8'h94, 1);
        run8("and_CB_2B", 4'd2,  8'hCB, 8'h2B, 8'h0B, 8'h10, 1);
        run8("sra_CA_3",  4'd9,  8'hCA, 8'h03, 8'hF9, 8'h84, 4);
        run8("sll_0F_6",  4'd6,  8'h0F, 8'h06, 8'hC0, 8'h85, 7);
        run8("sll_0F_9",  4'd6,  8'h0F, 8'h09, 8'h00, 8'h45, 9);
        run8("sra_CA_8",  4'd9,  8'hCA, 8'h08, 8'hFF, 8'h85, 9);
        run8("rot_CA_3",  4'd10, 8'hCA, 8'h03, 8'h56, 8'h04, 4);
        run8("test_07_3", 4'd15, 8'h07, 8'h03, 8'h07, 8'h50, 1);
        run8("set_00_7",  4'd13, 8'h00, 8'h07, 8'h80, 8'h50, 1);

        // Backpressure: result held while out_ready stays low
        issue8(4'd0, 8'h7F, 8'h01, lat);
        check("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, if8.out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, if8.in_ready}, 32'd0);
            check("bp_result", {24'd0, if8.result}, 32'h80);
            check("bp_flags", {24'd0, if8.flags}, 32'h94);
            $display("[TB] backpressure cycle %0d valid=%b ready=%b result=%h", i, if8.out_valid, if8.in_ready, if8.result);
        end
        pop8();

        // Reset in the middle of a long shift
        @(negedge clk);
        if8.opcode = 4'd6; if8.a = 8'h0F; if8.b = 8'h09; if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        check("mid_in_ready", {31'd0, if8.in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, if8.out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'd0, if8.in_ready}, 32'd1);
        check("rst_mid_result", {24'd0, if8.result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (if8.out_valid) saw_valid = 1'b1;
        end
        check("rst_no_stale", {31'd0, saw_valid}, 32'd0);
        check("rst_rel_in_ready", {31'd0, if8.in_ready}, 32'd1);
        $display("[TB] reset during shift: stale_output=%b in_ready=%b", saw_valid, if8.in_ready);

        // 16-bit wraparound add
        @(negedge clk);
        if16.opcode = 4'd0; if16.a = 16'hFFFF; if16.b = 16'h0001; if16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if16.in_valid = 1'b0;
        cyc16 = 1;
        while (!if16.out_valid && cyc16 < 100) begin
            @(posedge clk);
            #1;
            cyc16++;
        end
        check("w16_lat", cyc16, 1);
        check("w16_res", {16'd0, if16.result}, 32'h0000);
        check("w16_flags", {24'd0, if16.flags}, 32'h51);
        $display("[TB] w16 add FFFF+0001 -> result=%h flags=%h lat=%0d", if16.result, if16.flags, cyc16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
